trigb_mc: RTL and testbench
===========================

# trigb_mc

Multi-channel, pipelined successor to the single-channel TRIGB trigger stage of the ADPCM adaptive predictor. It accepts a stream of updated predictor coefficients (AnP) tagged with channel and coefficient index over a valid/ready handshake. When a tone/transition trigger (TR) occurs, it forces every coefficient of that channel's current frame to zero. Results (AnR) leave through a one-deep registered output stage. The block sits between the UPAx/UPB coefficient-update stages and the per-channel coefficient store of the MCAC datapath.

## Interface
Parameters:
- WIDTH, 16, coefficient width in bits
- NCH, 32, number of channels; CHW = max(1, $clog2(NCH))
- NCOEF, 8, coefficients per channel frame (A1, A2, B1..B6); IW = max(1, $clog2(NCOEF))

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- scan_in0..scan_in4  in  1  scan chain inputs
- scan_enable  in  1  scan shift enable
- test_mode  in  1  scan test mode
- scan_out0..scan_out4  out  1  scan chain outputs
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_ch  in  CHW  channel of the beat
- in_idx  in  IW  coefficient index within the frame
- TR  in  1  transition trigger qualifying this beat
- AnP  in  WIDTH  updated coefficient, two's complement
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out_ch  out  CHW  channel of the output beat
- out_idx  out  IW  index of the output beat
- AnR  out  WIDTH  coefficient after trigger
- tr_flags  out  NCH  per-channel trigger-in-progress flags

## Operation
- A beat is accepted on a rising edge where in_valid && in_ready.
- in_ready = !out_valid || out_ready, which gives full throughput with no bubble.
- Zero condition per beat: z = TR || tr_flags[in_ch].
- On acceptance, AnR is loaded with z ? 0 : AnP. out_ch and out_idx are loaded from the beat.
- Flag update on acceptance with in_ch < NCH:
  - in_idx == NCOEF-1: clear tr_flags[in_ch] (end of frame).
  - otherwise, if TR: set tr_flags[in_ch].
  - otherwise: hold.
- TR on the last index zeroes that beat only and leaves the flag clear.
- in_ch >= NCH: the beat passes through with z = TR only, and no flag changes.
- in_idx >= NCOEF is treated as a non-final index.
- Channels are independent. Interleaved frames of different channels keep separate flags.
- Output handshake:
  - out_valid sets on acceptance.
  - out_valid clears when out_ready is high and no new beat is accepted in that cycle.
  - Output data is held stable while out_valid && !out_ready.
- Scan ports carry no functional behaviour. scan_out* = 0 in RTL; chains are inserted in synthesis.

## Timing
- Reset values, applied asynchronously: out_valid=0, AnR=0, out_ch=0, out_idx=0, tr_flags=0. in_ready=1 once out_valid=0.
- Latency is exactly 1 cycle from acceptance to out_valid and AnR.
- A flag set by a beat in cycle n affects a same-channel beat accepted in cycle n+1. There is no stale read.
- Simultaneous drain and accept in one cycle: out_valid stays 1 and the new data replaces the old.
- Reset asserted mid-frame discards the pending output and all flags. The next frame starts clean.

## Configuration
- TRIGB_MC_STATS_EN defined:
  - Adds output tr_count [15:0].
  - tr_count increments on each accepted beat with TR=1 and tr_flags[in_ch]=0, i.e. once per triggered frame.
  - Saturates at 16'hFFFF. Resets to 0.
- Undefined: the port and counter are absent. Functional behaviour is otherwise identical.

## Structure
- Package trigb_pkg holds:
  - default WIDTH/NCH/NCOEF constants
  - a clog2-based width helper giving CHW/IW ≥ 1
  - typedef coef_t (signed WIDTH)
- Sub-module trigb_flag_bank contains the NCH flag registers, with a set/clear/index interface and an NCH-wide readout. The top level holds the handshake and output register.

## Test plan
- Reset release, then ch3, idx0..7, AnP=16'h1234, TR=0 -> AnR=16'h1234 on all 8 beats, 1-cycle latency, tr_flags=0.
- ch5 idx0 with TR=1, idx1..7 with TR=0, AnP=16'h7FFF -> all 8 AnR=0; tr_flags[5]=1 after idx0; tr_flags[5]=0 after idx7.
- Interleave ch1 (TR at idx2) with ch2 (no TR) -> ch1 idx0..1 pass and idx2..7 are 0; ch2 is untouched throughout.
- out_ready held low for 4 cycles with in_valid high -> in_ready=0, AnR/out_ch stable, no beat lost or duplicated after release.
- Assert reset mid-frame after ch7 TR at idx0 -> tr_flags=0, out_valid=0; the next ch7 frame with TR=0 passes AnP=16'hF00D unchanged.
- With TRIGB_MC_STATS_EN: 3 triggered frames -> tr_count=3. A second TR inside the same frame does not increment it.

Source files
------------

// File: rtl/trigb_pkg.sv
// Shared constants, width helper and coefficient type for the multi-channel TRIGB trigger stage.
package trigb_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int NCH_DEF   = 32;
    localparam int NCOEF_DEF = 8;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef logic signed [WIDTH_DEF-1:0] coef_t;

endpackage

// File: rtl/trigb_flag_bank.sv
// Per-channel trigger-in-progress flags with single-index set/clear and full-width readout.
module trigb_flag_bank
    import trigb_pkg::*;
#(
    parameter  int NCH = NCH_DEF,
    localparam int CHW = idx_w(NCH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           set_en,
    input  logic           clr_en,
    input  logic [CHW-1:0] idx,
    output logic [NCH-1:0] flags
);

    // Clear wins over set: a frame's last beat always leaves the channel idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= '0;
        end else if (clr_en) begin
            flags[idx] <= 1'b0;
        end else if (set_en) begin
            flags[idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/trigb_mc.sv
// Multi-channel TRIGB trigger stage: zeroes a channel's frame after TR, one-deep registered output.
// Optional trigger statistics counter enabled by defining TRIGB_MC_STATS_EN.
module trigb_mc
    import trigb_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int NCH   = NCH_DEF,
    parameter  int NCOEF = NCOEF_DEF,
    localparam int CHW   = idx_w(NCH),
    localparam int IW    = idx_w(NCOEF)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    scan_in0,
    input  logic                    scan_in1,
    input  logic                    scan_in2,
    input  logic                    scan_in3,
    input  logic                    scan_in4,
    input  logic                    scan_enable,
    input  logic                    test_mode,
    output logic                    scan_out0,
    output logic                    scan_out1,
    output logic                    scan_out2,
    output logic                    scan_out3,
    output logic                    scan_out4,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CHW-1:0]          in_ch,
    input  logic [IW-1:0]           in_idx,
    input  logic                    TR,
    input  logic signed [WIDTH-1:0] AnP,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CHW-1:0]          out_ch,
    output logic [IW-1:0]           out_idx,
    output logic signed [WIDTH-1:0] AnR,
    output logic [NCH-1:0]          tr_flags
`ifdef TRIGB_MC_STATS_EN
    ,
    output logic [15:0]             tr_count
`endif
);

    localparam logic [CHW:0]  NCH_L    = NCH[CHW:0];
    localparam logic [IW-1:0] LAST_IDX = IW'(NCOEF - 1);

    logic          accept_p0;
    logic          ch_ok_p0;
    logic          last_p0;
    logic          cur_flag_p0;
    logic          zero_p0;
    logic          vld_p1;
    logic [CHW-1:0] ch_p1;
    logic [IW-1:0]  idx_p1;
    logic signed [WIDTH-1:0] anr_p1;
    logic          unused_scan;

    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;
    assign unused_scan = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                           scan_enable, test_mode};

    // ---- stage p0: accept, zero decision, flag update ----
    assign in_ready    = !vld_p1 || out_ready;
    assign accept_p0   = in_valid && in_ready;
    assign ch_ok_p0    = {1'b0, in_ch} < NCH_L;
    assign last_p0     = (in_idx == LAST_IDX);
    assign cur_flag_p0 = ch_ok_p0 ? tr_flags[in_ch] : 1'b0;
    assign zero_p0     = TR || cur_flag_p0;

    trigb_flag_bank #(.NCH(NCH)) u_flags (
        .clk    (clk),
        .reset  (reset),
        .set_en (accept_p0 && ch_ok_p0 && !last_p0 && TR),
        .clr_en (accept_p0 && ch_ok_p0 && last_p0),
        .idx    (in_ch),
        .flags  (tr_flags)
    );

    // ---- stage p1: registered output, held while stalled ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            anr_p1 <= '0;
            ch_p1  <= '0;
            idx_p1 <= '0;
        end else if (accept_p0) begin
            vld_p1 <= 1'b1;
            anr_p1 <= zero_p0 ? '0 : AnP;
            ch_p1  <= in_ch;
            idx_p1 <= in_idx;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign AnR       = anr_p1;
    assign out_ch    = ch_p1;
    assign out_idx   = idx_p1;

`ifdef TRIGB_MC_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Counts the first trigger of each frame; repeat TRs inside a frame see the flag already set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tr_count <= '0;
        end else if (accept_p0 && TR && !cur_flag_p0) begin
            tr_count <= sat_inc(tr_count);
        end
    end
`endif

endmodule

// File: tb/tb_trigb_mc.sv
// Directed self-checking bench for trigb_mc with hand-computed expected values.
module tb_trigb_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, tr;
    logic [4:0]  in_ch, out_ch;
    logic [2:0]  in_idx, out_idx;
    logic signed [15:0] anp, anr;
    logic [31:0] tr_flags;
    logic        so0, so1, so2, so3, so4;
`ifdef TRIGB_MC_STATS_EN
    logic [15:0] tr_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    trigb_mc dut (
        .clk(clk), .reset(reset),
        .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0), .scan_in3(1'b0), .scan_in4(1'b0),
        .scan_enable(1'b0), .test_mode(1'b0),
        .scan_out0(so0), .scan_out1(so1), .scan_out2(so2), .scan_out3(so3), .scan_out4(so4),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_idx(in_idx),
        .TR(tr), .AnP(anp),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_idx(out_idx),
        .AnR(anr), .tr_flags(tr_flags)
`ifdef TRIGB_MC_STATS_EN
        , .tr_count(tr_count)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Present one beat, clock it in, then check the registered result one cycle later.
    task automatic beat(input int ch, input int idx, input logic t,
                        input logic [15:0] a, input logic [15:0] exp);
        logic [31:0] chv, idxv;
        chv = ch;
        idxv = idx;
        in_valid = 1'b1;
        in_ch    = chv[4:0];
        in_idx   = idxv[2:0];
        tr       = t;
        anp      = a;
        @(posedge clk);
        #1;
        check_eq("beat_valid", {31'b0, out_valid}, 32'd1);
        check_eq("beat_anr",   {16'b0, anr}, {16'b0, exp});
        check_eq("beat_ch",    {27'b0, out_ch}, chv);
        check_eq("beat_idx",   {29'b0, out_idx}, idxv);
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        tr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0; in_ch = '0; in_idx = '0; tr = 1'b0; anp = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_anr", {16'b0, anr}, 32'd0);
        check_eq("rst_flags", tr_flags, 32'd0);
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("scan_out", {27'b0, so0, so1, so2, so3, so4}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Plain frame on ch3
        for (int i = 0; i < 8; i++) beat(3, i, 1'b0, 16'h1234, 16'h1234);
        check_eq("ch3_flags", tr_flags, 32'd0);

        // Triggered frame on ch5
        beat(5, 0, 1'b1, 16'h7FFF, 16'h0000);
        check_eq("ch5_flag_set", tr_flags, 32'h0000_0020);
        for (int i = 1; i < 8; i++) beat(5, i, 1'b0, 16'h7FFF, 16'h0000);
        check_eq("ch5_flag_clr", tr_flags, 32'd0);

        // Interleaved ch1 (TR at idx2) and ch2 (no TR)
        for (int i = 0; i < 8; i++) begin
            beat(1, i, (i == 2), 16'h1111, (i < 2) ? 16'h1111 : 16'h0000);
            beat(2, i, 1'b0, 16'h2222, 16'h2222);
            if (i == 4) check_eq("ilv_flags", tr_flags, 32'h0000_0002);
        end
        check_eq("ilv_flags_end", tr_flags, 32'd0);

        // Backpressure: held output, stalled input, then release
        beat(4, 0, 1'b0, 16'hAAAA, 16'hAAAA);
        out_ready = 1'b0;
        in_valid = 1'b1; in_ch = 5'd4; in_idx = 3'd1; tr = 1'b0; anp = 16'hBBBB;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check_eq("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check_eq("bp_anr", {16'b0, anr}, 32'h0000_AAAA);
            check_eq("bp_idx", {29'b0, out_idx}, 32'd0);
            check_eq("bp_valid", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check_eq("bp_anr_new", {16'b0, anr}, 32'h0000_BBBB);
        check_eq("bp_idx_new", {29'b0, out_idx}, 32'd1);
        idle_cycle();
        check_eq("bp_drained", {31'b0, out_valid}, 32'd0);
        for (int i = 2; i < 8; i++) beat(4, i, 1'b0, 16'hCCCC, 16'hCCCC);

        // Mid-frame reset after ch7 trigger
        beat(7, 0, 1'b1, 16'h5555, 16'h0000);
        check_eq("ch7_flag_set", tr_flags, 32'h0000_0080);
        #2;
        reset = 1'b0;
        #1;
        check_eq("mid_rst_flags", tr_flags, 32'd0);
        check_eq("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check_eq("mid_rst_anr", {16'b0, anr}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) beat(7, i, 1'b0, 16'hF00D, 16'hF00D);

        // Three triggered frames on ch0, each with a second TR inside the frame
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 8; i++)
                beat(0, i, (i == 0 || i == 3), 16'h0F0F, 16'h0000);
`ifdef TRIGB_MC_STATS_EN
        check_eq("tr_count", {16'b0, tr_count}, 32'd3);
`endif

        // TR on the last index zeroes that beat only and leaves the flag clear
        beat(6, 7, 1'b1, 16'h4321, 16'h0000);
        check_eq("last_tr_flags", tr_flags, 32'd0);
        beat(6, 0, 1'b0, 16'h4321, 16'h4321);
        idle_cycle();
        check_eq("final_drain", {31'b0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
